// File: rtl/sprite_plotter_if.sv
// sprite_plotter_if: draw request handshake, sprite ROM port and VGA pixel-write bus
interface sprite_plotter_if #(
    parameter int ADDR_W  = 5,
    parameter int X_W     = 8,
    parameter int Y_W     = 7,
    parameter int COLOR_W = 3
);
    logic               start;
    logic [X_W-1:0]     base_x;
    logic [Y_W-1:0]     base_y;
    logic [ADDR_W-1:0]  rom_addr;
    logic [COLOR_W-1:0] rom_data;
    logic [X_W-1:0]     vga_x;
    logic [Y_W-1:0]     vga_y;
    logic [COLOR_W-1:0] vga_colour;
    logic               vga_plot;
    logic               busy;
    logic               done;

    modport master (
        output start, base_x, base_y, rom_data,
        input  rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );

    modport slave (
        input  start, base_x, base_y, rom_data,
        output rom_addr, vga_x, vga_y, vga_colour, vga_plot, busy, done
    );
endinterface

// File: rtl/sprite_plotter.sv
// sprite_plotter: walks a sprite ROM row-major and issues one clipped, non-transparent VGA write per pixel
module sprite_plotter #(
    parameter int                 SPR_W       = 5,
    parameter int                 SPR_H       = 5,
    parameter int                 ADDR_W      = 5,
    parameter int                 X_W         = 8,
    parameter int                 Y_W         = 7,
    parameter int                 COLOR_W     = 3,
    parameter int                 X_MAX       = 160,
    parameter int                 Y_MAX       = 120,
    parameter logic [COLOR_W-1:0] TRANSPARENT = '0
) (
    input logic             clk,
    input logic             reset,
    sprite_plotter_if.slave bus
);
    localparam int N  = SPR_W * SPR_H;
    localparam int CW = SPR_W > 1 ? $clog2(SPR_W) : 1;
    localparam int RW = SPR_H > 1 ? $clog2(SPR_H) : 1;

    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

    state_t          state, state_nx;
    logic [X_W-1:0]  bx;
    logic [Y_W-1:0]  by;
    logic [CW-1:0]   col, s1_col;
    logic [RW-1:0]   row, s1_row;
    logic            s0_v, s1_v;
    logic            last;
    logic [X_W:0]    sx;
    logic [Y_W:0]    sy;

    always_ff @(posedge clk)
        state <= reset ? IDLE : state_nx;

    always_comb begin
        last     = bus.rom_addr == ADDR_W'(N - 1);
        state_nx = state == IDLE  ? (bus.start ? FETCH : IDLE) :
                   state == FETCH ? (last ? DRAIN : FETCH) :
                   state == DRAIN ? (!s0_v && !s1_v ? DONE : DRAIN) : IDLE;
    end

    always_comb begin
        bus.busy = state != IDLE;
        bus.done = state == DONE;
    end

    // Sums carry one extra bit so coordinates that wrap on truncation are still clipped
    always_comb begin
        sx = (X_W+1)'(bx) + (X_W+1)'(s1_col);
        sy = (Y_W+1)'(by) + (Y_W+1)'(s1_row);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bx             <= '0;
            by             <= '0;
            col            <= '0;
            row            <= '0;
            s0_v           <= 1'b0;
            s1_v           <= 1'b0;
            s1_col         <= '0;
            s1_row         <= '0;
            bus.rom_addr   <= '0;
            bus.vga_x      <= '0;
            bus.vga_y      <= '0;
            bus.vga_colour <= '0;
            bus.vga_plot   <= 1'b0;
        end else begin
            s1_v           <= s0_v;
            s1_col         <= col;
            s1_row         <= row;
            bus.vga_x      <= sx[X_W-1:0];
            bus.vga_y      <= sy[Y_W-1:0];
            bus.vga_colour <= bus.rom_data;
            bus.vga_plot   <= s1_v && bus.rom_data != TRANSPARENT &&
                              sx < (X_W+1)'(X_MAX) && sy < (Y_W+1)'(Y_MAX);
            if (state == IDLE && bus.start) begin
                bx           <= bus.base_x;
                by           <= bus.base_y;
                col          <= '0;
                row          <= '0;
                s0_v         <= 1'b1;
                bus.rom_addr <= '0;
            end else if (state == FETCH) begin
                s0_v <= !last;
                if (!last) begin
                    bus.rom_addr <= bus.rom_addr + ADDR_W'(1);
                    col          <= col == CW'(SPR_W - 1) ? '0 : col + CW'(1);
                    row          <= col == CW'(SPR_W - 1) ? row + RW'(1) : row;
                end
            end
        end
    end
endmodule

// File: tb/tb_sprite_plotter.sv
// tb_sprite_plotter: directed draws against a ROM model with a scoreboard of expected pixel writes
module tb_sprite_plotter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic [2:0] rom [32];

    typedef struct {
        int cyc;
        int x;
        int y;
        int colour;
    } exp_t;
    exp_t sb [$];

    sprite_plotter_if bus ();

    sprite_plotter dut (.clk(clk), .reset(reset), .bus(bus));

    always #5 clk = ~clk;

    always @(posedge clk) bus.rom_data <= rom[bus.rom_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Draws one sprite from edge E0; restart_cyc injects an extra start, reset_cyc a mid-draw reset
    task automatic run_draw(input int bx, input int by, input int restart_cyc, input int reset_cyc,
                            input string name);
        int   nexp = 0;
        int   nplot = 0;
        exp_t e;
        sb.delete();
        for (int k = 0; k < 25; k++) begin
            e.cyc    = k + 2;
            e.x      = bx + k % 5;
            e.y      = by + k / 5;
            e.colour = int'(rom[k]);
            if (e.colour != 0 && e.x < 160 && e.y < 120 && (reset_cyc == 0 || e.cyc < reset_cyc)) begin
                sb.push_back(e);
                nexp++;
            end
        end
        bus.start  = 1'b1;
        bus.base_x = 8'(bx);
        bus.base_y = 7'(by);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        check({name, "_busy0"}, 32'(bus.busy), 1);
        check({name, "_addr0"}, 32'(bus.rom_addr), 0);
        for (int cyc = 1; cyc <= 30; cyc++) begin
            @(posedge clk);
            #1;
            if (reset_cyc != 0 && cyc == reset_cyc) begin
                check({name, "_rst_plot"}, 32'(bus.vga_plot), 0);
                check({name, "_rst_busy"}, 32'(bus.busy), 0);
                check({name, "_rst_addr"}, 32'(bus.rom_addr), 0);
                check({name, "_rst_done"}, 32'(bus.done), 0);
                reset = 1'b0;
                break;
            end
            check({name, "_done"}, 32'(bus.done), (reset_cyc == 0 && cyc == 27) ? 1 : 0);
            check({name, "_busy"}, 32'(bus.busy), cyc <= 27 ? 1 : 0);
            if (cyc <= 27)
                check({name, "_addr"}, 32'(bus.rom_addr), cyc < 24 ? cyc : 24);
            if (bus.vga_plot === 1'b1) begin
                nplot++;
                if (sb.size() == 0) begin
                    check({name, "_extra_plot_cyc"}, 32'(cyc), 0);
                end else begin
                    e = sb.pop_front();
                    check({name, "_plot_cyc"}, 32'(cyc), 32'(e.cyc));
                    check({name, "_x"}, 32'(bus.vga_x), 32'(e.x));
                    check({name, "_y"}, 32'(bus.vga_y), 32'(e.y));
                    check({name, "_colour"}, 32'(bus.vga_colour), 32'(e.colour));
                end
            end
            if (cyc == restart_cyc - 1) begin
                bus.start  = 1'b1;
                bus.base_x = '0;
                bus.base_y = '0;
            end
            if (cyc == restart_cyc) bus.start = 1'b0;
            if (reset_cyc != 0 && cyc == reset_cyc - 1) reset = 1'b1;
        end
        check({name, "_nplots"}, 32'(nplot), 32'(nexp));
        check({name, "_sb_empty"}, 32'(sb.size()), 0);
    endtask

    initial begin
        bus.start  = 1'b0;
        bus.base_x = '0;
        bus.base_y = '0;
        for (int i = 0; i < 32; i++) rom[i] = 3'b111;
        repeat (3) @(posedge clk);
        #1;
        check("reset_plot", 32'(bus.vga_plot), 0);
        check("reset_busy", 32'(bus.busy), 0);
        check("reset_done", 32'(bus.done), 0);
        check("reset_addr", 32'(bus.rom_addr), 0);
        check("reset_x", 32'(bus.vga_x), 0);
        check("reset_y", 32'(bus.vga_y), 0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        run_draw(10, 20, 0, 0, "opaque");
        for (int i = 0; i < 32; i++) rom[i] = i[0] ? 3'b100 : 3'b000;
        run_draw(10, 20, 0, 0, "checker");
        for (int i = 0; i < 32; i++) rom[i] = 3'b111;
        run_draw(157, 118, 0, 0, "clip");
        run_draw(255, 127, 0, 0, "wrap");
        run_draw(30, 40, 5, 0, "ignore");
        run_draw(0, 0, 0, 0, "origin");
        for (int i = 0; i < 32; i++) rom[i] = 3'(i % 7 + 1);
        run_draw(50, 60, 0, 10, "midreset");
        run_draw(50, 60, 0, 0, "redraw");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
